// File: rtl/pong_pkg.sv
// Shared pong definitions: match FSM state encodings and default game constants,
// used by the match controller and the LED/SSD display decoding.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_DONE  = 3'd4,
    ST_PAUSE = 3'd5
  } state_e;

  localparam int DEF_WIN_SCORE   = 10;
  localparam int DEF_SERVE_TICKS = 64;

endpackage

// File: rtl/score_counter.sv
// Saturating per-player score counter with synchronous clear.
module score_counter #(
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] value
);

  logic [SCORE_W-1:0] value_q, value_d;

  // Next value: clear has priority, increments stop at all-ones instead of wrapping.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = {SCORE_W{1'b0}};
    end else if (inc && (value_q != {SCORE_W{1'b1}})) begin
      value_d = value_q + SCORE_W'(1);
    end else begin
      value_d = value_q;
    end
  end

  // Score register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= {SCORE_W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/match_ctrl.sv
// Match/scoring controller: serve timing, point accounting, pause and win detection
// between the ball state machine and the score/LED display logic.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int WIN_BY_TWO  = 0,
  parameter int SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int PID_W       = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           point_valid,
  input  logic [PID_W-1:0]               point_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [2:0]                     state,
  output logic [PID_W-1:0]               serve_player,
  output logic                           ball_enable,
  output logic                           ball_release,
  output logic [PID_W-1:0]               winner,
  output logic                           winner_valid
);

  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  state_e             state_q, state_d;
  logic               start_q;
  logic               start_rise_s;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic [PID_W-1:0]   serve_player_q, serve_player_d;
  logic [PID_W-1:0]   winner_q, winner_d;
  logic [PID_W-1:0]   scorer_q, scorer_d;
  logic               from_play_q, from_play_d;
  logic               ball_release_q, ball_release_d;
  logic               ball_enable_q, winner_valid_q;
  logic               clr_s, point_ok_s, win_s, lead_ok_s;
  logic [NUM_PLAYERS-1:0] inc_s;
  logic [SCORE_W-1:0] score_arr [NUM_PLAYERS];
  logic [SCORE_W-1:0] scorer_score_s;

  assign start_rise_s = start & ~start_q;
  // Out-of-range scorer indices never reach the counters.
  assign point_ok_s   = point_valid &&
                        ({1'b0, point_player} < (PID_W+1)'(NUM_PLAYERS));

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
    score_counter #(.SCORE_W(SCORE_W)) u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .inc   (inc_s[p]),
      .value (score_arr[p])
    );
    assign scores[p*SCORE_W +: SCORE_W] = score_arr[p];
  end

  // Route an accepted point in PLAY to the scorer's counter.
  always_comb begin
    inc_s = {NUM_PLAYERS{1'b0}};
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if ((state_q == ST_PLAY) && point_ok_s && (point_player == PID_W'(p))) begin
        inc_s[p] = 1'b1;
      end else begin
        inc_s[p] = 1'b0;
      end
    end
  end

  // Win test for the last scorer on the registered scores (only the scorer can newly win).
  always_comb begin
    scorer_score_s = {SCORE_W{1'b0}};
    lead_ok_s      = 1'b1;
    win_s          = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (scorer_q == PID_W'(p)) begin
        scorer_score_s = score_arr[p];
      end else begin
        scorer_score_s = scorer_score_s;
      end
    end
    for (int q = 0; q < NUM_PLAYERS; q++) begin
      if ((WIN_BY_TWO != 0) && (scorer_q != PID_W'(q)) &&
          ({1'b0, scorer_score_s} < ({1'b0, score_arr[q]} + (SCORE_W+1)'(2)))) begin
        lead_ok_s = 1'b0;
      end else begin
        lead_ok_s = lead_ok_s;
      end
    end
    win_s = (scorer_score_s >= SCORE_W'(WIN_SCORE)) && lead_ok_s;
  end

  // Next-state logic: serve countdown, point handling, pause/resume and match restart.
  always_comb begin
    state_d        = state_q;
    serve_cnt_d    = serve_cnt_q;
    serve_player_d = serve_player_q;
    winner_d       = winner_q;
    scorer_d       = scorer_q;
    from_play_d    = from_play_q;
    ball_release_d = 1'b0;
    clr_s          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clr_s = 1'b1;
        if (start_rise_s) begin
          state_d        = ST_SERVE;
          serve_cnt_d    = {CNT_W{1'b0}};
          serve_player_d = {PID_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (!start) begin
          state_d     = ST_PAUSE;
          from_play_d = 1'b0;
        end else if (tick) begin
          if (serve_cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
            state_d        = ST_PLAY;
            serve_cnt_d    = {CNT_W{1'b0}};
            ball_release_d = 1'b1;
          end else begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_PLAY: begin
        // A point in the same cycle as start falling is counted before pausing.
        if (point_ok_s) begin
          state_d  = ST_POINT;
          scorer_d = point_player;
        end else if (!start) begin
          state_d     = ST_PAUSE;
          from_play_d = 1'b1;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_POINT: begin
        if (win_s) begin
          state_d  = ST_DONE;
          winner_d = scorer_q;
        end else begin
          state_d        = ST_SERVE;
          serve_player_d = scorer_q;
          serve_cnt_d    = {CNT_W{1'b0}};
        end
      end
      ST_DONE: begin
        if (start_rise_s) begin
          state_d        = ST_SERVE;
          clr_s          = 1'b1;
          serve_player_d = winner_q;
          serve_cnt_d    = {CNT_W{1'b0}};
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (start) begin
          state_d = from_play_q ? ST_PLAY : ST_SERVE;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; outputs are registered from the next-state values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      start_q        <= 1'b0;
      serve_cnt_q    <= {CNT_W{1'b0}};
      serve_player_q <= {PID_W{1'b0}};
      winner_q       <= {PID_W{1'b0}};
      scorer_q       <= {PID_W{1'b0}};
      from_play_q    <= 1'b0;
      ball_release_q <= 1'b0;
      ball_enable_q  <= 1'b0;
      winner_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start;
      serve_cnt_q    <= serve_cnt_d;
      serve_player_q <= serve_player_d;
      winner_q       <= winner_d;
      scorer_q       <= scorer_d;
      from_play_q    <= from_play_d;
      ball_release_q <= ball_release_d;
      ball_enable_q  <= (state_d == ST_PLAY);
      winner_valid_q <= (state_d == ST_DONE);
    end
  end

  assign state        = state_q;
  assign serve_player = serve_player_q;
  assign ball_enable  = ball_enable_q;
  assign ball_release = ball_release_q;
  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;

endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
- Parametrised match/scoring controller for the pong game. It generalises the fixed two-player, 2-bit game-state LEDs and raw score wires into a real state machine.
- Features: N players, configurable win score, optional win-by-two, timed serve delay, pause, and a one-cycle ball-release strobe.
- Placement: sits between the ball state machine (point events in, release/enable out) and the LED/SSD display logic (state, scores, winner out).

Parameters:
- NUM_PLAYERS, 2, number of players/score channels (2..8).
- SCORE_W, 4, bits per score counter; scores saturate at 2^SCORE_W-1.
- WIN_SCORE, 10, points needed to win (must be < 2^SCORE_W).
- WIN_BY_TWO, 0, 1 = winner must also lead every other player by >= 2.
- SERVE_TICKS, 64, tick strobes spent in SERVE before ball release (>= 1).
- PID_W, 1, player index width, >= clog2(NUM_PLAYERS).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle game-tick strobe (frame rate).
- start  in  1  level from the start switch; rising edge is detected internally.
- point_valid  in  1  one-cycle pulse: a point was scored.
- point_player  in  PID_W  scorer index, sampled when point_valid = 1.
- scores  out  NUM_PLAYERS*SCORE_W  packed scores, player 0 in the LSBs.
- state  out  3  encoded FSM state.
- serve_player  out  PID_W  player currently serving.
- ball_enable  out  1  high only in PLAY.
- ball_release  out  1  one-cycle pulse on the SERVE->PLAY transition.
- winner  out  PID_W  winning player index, valid when winner_valid = 1.
- winner_valid  out  1  high only in DONE.

Behaviour:
- Clocking and reset:
  - All state is registered on posedge clk.
  - While reset = 0: state = IDLE, all scores = 0, serve_player = 0, serve counter = 0, winner = 0, ball_enable = 0, ball_release = 0, winner_valid = 0, start edge register = 0.
  - Reset wins over every other input in the same cycle.
- Start edge: start_q is registered every cycle; start_rise = start & ~start_q.
- States: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, DONE = 4, PAUSE = 5.
- IDLE:
  - Scores held at 0.
  - start_rise -> SERVE; serve counter cleared; serve_player = 0.
- SERVE:
  - Each tick increments the serve counter.
  - A tick with counter == SERVE_TICKS-1 -> PLAY, with ball_release = 1 for exactly that next cycle.
- PLAY:
  - ball_enable = 1.
  - point_valid with point_player < NUM_PLAYERS: the scorer's counter increments (saturating) and the FSM goes to POINT, one cycle later.
  - point_valid with an out-of-range point_player is ignored; the FSM stays in PLAY.
- POINT (exactly one cycle, evaluated on the registered scores):
  - Win test: score[p] >= WIN_SCORE, and if WIN_BY_TWO = 1, score[p] >= score[q]+2 for all q != p.
  - Win true -> DONE, winner = p.
  - Win false -> SERVE; serve_player = p (scorer serves); serve counter cleared.
- Latency: point_valid at cycle n -> score visible at n+1 -> state SERVE or DONE at n+2.
- PAUSE:
  - start = 0 while in SERVE or PLAY -> PAUSE; the prior state is saved (1 bit).
  - In PAUSE: ticks are ignored, the serve counter holds, point_valid is ignored, ball_enable = 0.
  - start = 1 -> return to the saved state, with no ball_release re-issue when returning to PLAY.
  - start falling in the same cycle as point_valid: the point is counted first (-> POINT). POINT never pauses.
- DONE:
  - winner_valid = 1; scores frozen; point_valid ignored.
  - start_rise -> SERVE with scores cleared, serve_player = winner, counter cleared.
- Saturation: a score at 2^SCORE_W-1 does not wrap. This case is only reachable with WIN_BY_TWO = 1.
- tick arriving in the same cycle as the SERVE entry is not counted.

Decomposition:
- Shared package pong_pkg holds:
  - State encoding constants (ST_IDLE..ST_PAUSE, 3 bits).
  - Defaults for WIN_SCORE and SERVE_TICKS, shared with the display/LED logic so LD decoding uses the same encodings.
- One natural sub-module: score_counter, instantiated NUM_PLAYERS times.
  - Ports: clk, reset, clr, inc, value.
  - Behaviour: saturating SCORE_W-bit counter with synchronous clear.
- The FSM, win comparator loop and serve counter stay in match_ctrl.

Test Plan:
- Reset/start: reset = 0 for 3 cycles, then start rises -> state 1; after 64 ticks, state 2 and a single-cycle ball_release. Scores all 0 throughout.
- First to win: player 1 scores 10 points (WIN_BY_TWO = 0) -> after the 10th point_valid, state DONE two cycles later; winner = 1, winner_valid = 1, scores = {10, p0 score}.
- Win-by-two: with WIN_BY_TWO = 1, scores reach 10-10, then 11-10 -> no DONE. Then 12-10 -> DONE, winner = 0.
- Pause: start dropped at serve count 30 -> state 5, counter holds across 20 ticks. start restored -> SERVE; release occurs 34 ticks later.
- Illegal/ignored points: point_player = 3 with NUM_PLAYERS = 2 in PLAY, and point_valid in SERVE/DONE -> scores and state unchanged.
- Mid-operation reset: reset = 0 during PLAY with scores 7-5 -> next cycle state IDLE, scores 0, ball_enable 0, no ball_release.
